// File: rtl/bcd_entry_to_bin_if.sv
// Signal bundle between the operator switch/button panel and the BCD entry block.
// The master side drives the raw panel inputs; the slave side returns the accepted value and digit echoes.
interface bcd_entry_to_bin_if #(
  parameter int OUT_WIDTH = 6
);
  logic [3:0]           digit_in;
  logic                 enter_btn;
  logic                 clear_btn;
  logic [OUT_WIDTH-1:0] value_out;
  logic                 value_valid;
  logic                 err;
  logic [3:0]           tens_digit;
  logic [3:0]           units_digit;
  logic [1:0]           entry_state;

  modport master (
    output digit_in, enter_btn, clear_btn,
    input  value_out, value_valid, err, tens_digit, units_digit, entry_state
  );

  modport slave (
    input  digit_in, enter_btn, clear_btn,
    output value_out, value_valid, err, tens_digit, units_digit, entry_state
  );
endinterface

// File: rtl/bcd_entry_to_bin.sv
// Two-digit decimal entry from slide switches plus debounced ENTER/CLEAR buttons.
// The result is rebuilt into a range-checked binary value, and the entered digits are echoed for display.
module bcd_entry_to_bin #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OUT_WIDTH       = 6,
  parameter int MAX_VALUE       = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_entry_to_bin_if.slave bus
);
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]      MAX_SUM  = 7'(MAX_VALUE);

  typedef enum logic [1:0] {
    ST_TENS  = 2'd0,
    ST_UNITS = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // Button index 0 is ENTER, index 1 is CLEAR.
  logic [1:0]         w_raw;
  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         r_db;
  logic [1:0]         r_db_prev;
  logic [1:0]         r_press;
  logic [1:0][CW-1:0] r_cnt;

  assign w_raw = {bus.clear_btn, bus.enter_btn};

  // Synchronise, debounce and edge-detect both buttons
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 2'b00;
      r_sync2   <= 2'b00;
      r_db      <= 2'b00;
      r_db_prev <= 2'b00;
      r_press   <= 2'b00;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      r_press   <= r_db & ~r_db_prev;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  state_t               r_state;
  state_t               w_state_nx;
  logic [3:0]           r_tens;
  logic [3:0]           w_tens_nx;
  logic [3:0]           r_units;
  logic [3:0]           w_units_nx;
  logic [OUT_WIDTH-1:0] r_value;
  logic [OUT_WIDTH-1:0] w_value_nx;
  logic                 r_valid;
  logic                 w_valid_nx;
  logic                 r_err;
  logic                 w_digit_ok;
  logic [6:0]           w_sum;

  assign w_digit_ok = (bus.digit_in <= 4'd9);
  // r_tens never exceeds 9 in UNITS, so the sum stays within 99 and fits 7 bits
  assign w_sum      = ({3'b000, r_tens} * 7'd10) + {3'b000, bus.digit_in};

  // Entry FSM: next state, digit latches and value update
  always_comb begin
    w_state_nx = r_state;
    w_tens_nx  = r_tens;
    w_units_nx = r_units;
    w_value_nx = r_value;
    w_valid_nx = 1'b0;
    if (r_press[1]) begin
      w_state_nx = ST_TENS;
      w_tens_nx  = 4'd0;
      w_units_nx = 4'd0;
    end else if (r_press[0]) begin
      case (r_state)
        ST_TENS, ST_DONE: begin
          if (!w_digit_ok) begin
            w_state_nx = ST_ERR;
          end else begin
            w_tens_nx  = bus.digit_in;
            w_units_nx = 4'd0;
            w_state_nx = ST_UNITS;
          end
        end
        ST_UNITS: begin
          if (!w_digit_ok) begin
            w_state_nx = ST_ERR;
          end else begin
            w_units_nx = bus.digit_in;
            if (w_sum > MAX_SUM) begin
              w_state_nx = ST_ERR;
            end else begin
              w_value_nx = OUT_WIDTH'(w_sum);
              w_valid_nx = 1'b1;
              w_state_nx = ST_DONE;
            end
          end
        end
        ST_ERR: begin
          w_state_nx = ST_ERR;
        end
        default: begin
          w_state_nx = ST_TENS;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_TENS;
      r_tens  <= 4'd0;
      r_units <= 4'd0;
      r_value <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_tens  <= w_tens_nx;
      r_units <= w_units_nx;
      r_value <= w_value_nx;
      r_valid <= w_valid_nx;
      r_err   <= (w_state_nx == ST_ERR);
    end
  end

  assign bus.value_out   = r_value;
  assign bus.value_valid = r_valid;
  assign bus.err         = r_err;
  assign bus.tens_digit  = r_tens;
  assign bus.units_digit = r_units;
  assign bus.entry_state = r_state;
endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// Directed bench for bcd_entry_to_bin with DEBOUNCE_CYCLES=4; accepted values are
// checked against a queue of expected results filled as each entry is driven.
module tb_bcd_entry_to_bin;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  logic prev_valid = 1'b0;
  logic [5:0] exp_q[$];

  bcd_entry_to_bin_if #(.OUT_WIDTH(6)) bus ();

  bcd_entry_to_bin #(
    .DEBOUNCE_CYCLES(D),
    .OUT_WIDTH(6),
    .MAX_VALUE(63)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every value_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (bus.value_valid === 1'b1) begin
      pulses++;
      chk("valid_back_to_back", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() > 0) chk("scoreboard_value", {26'd0, bus.value_out}, {26'd0, exp_q.pop_front()});
      else chk("unexpected_valid", exp_q.size(), 32'd1);
    end
    prev_valid = bus.value_valid;
  end

  task automatic press_enter(input logic [3:0] d);
    @(negedge clk);
    bus.digit_in  = d;
    bus.enter_btn = 1'b1;
    repeat (D + 8) @(posedge clk);
    @(negedge clk);
    bus.enter_btn = 1'b0;
    repeat (D + 8) @(posedge clk);
    #1;
  endtask

  task automatic press_clear();
    @(negedge clk);
    bus.clear_btn = 1'b1;
    repeat (D + 8) @(posedge clk);
    @(negedge clk);
    bus.clear_btn = 1'b0;
    repeat (D + 8) @(posedge clk);
    #1;
  endtask

  int p0;

  initial begin
    bus.digit_in  = 4'd0;
    bus.enter_btn = 1'b0;
    bus.clear_btn = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_value_out", {26'd0, bus.value_out}, 32'd0);
    chk("rst_value_valid", {31'd0, bus.value_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_tens", {28'd0, bus.tens_digit}, 32'd0);
    chk("rst_units", {28'd0, bus.units_digit}, 32'd0);
    chk("rst_state", {30'd0, bus.entry_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_no_valid", pulses, 32'd0);

    // Tens digit 4 with exact press latency
    @(negedge clk);
    bus.digit_in  = 4'd4;
    bus.enter_btn = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("tens_before_edge8", {28'd0, bus.tens_digit}, 32'd0);
    @(posedge clk);
    #1;
    chk("tens_at_edge8", {28'd0, bus.tens_digit}, 32'd4);
    chk("state_units", {30'd0, bus.entry_state}, 32'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.enter_btn = 1'b0;
    repeat (12) @(posedge clk);

    // Units digit 2 -> 42, valid for exactly one cycle
    exp_q.push_back(6'd42);
    @(negedge clk);
    bus.digit_in  = 4'd2;
    bus.enter_btn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("valid_high_edge8", {31'd0, bus.value_valid}, 32'd1);
    chk("value_42", {26'd0, bus.value_out}, 32'd42);
    @(posedge clk);
    #1;
    chk("valid_low_edge9", {31'd0, bus.value_valid}, 32'd0);
    chk("state_done", {30'd0, bus.entry_state}, 32'd2);
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.enter_btn = 1'b0;
    repeat (12) @(posedge clk);

    // Short glitches produce no press
    @(negedge clk); bus.digit_in = 4'd7; bus.enter_btn = 1'b1;
    repeat (2) @(negedge clk);
    bus.enter_btn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch2_state", {30'd0, bus.entry_state}, 32'd2);
    @(negedge clk); bus.enter_btn = 1'b1;
    @(negedge clk); bus.enter_btn = 1'b0;
    @(negedge clk); bus.enter_btn = 1'b1;
    repeat (3) @(negedge clk);
    bus.enter_btn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("bounce_state", {30'd0, bus.entry_state}, 32'd2);
    chk("bounce_tens", {28'd0, bus.tens_digit}, 32'd4);

    // Held ENTER gives a single press
    p0 = pulses;
    @(negedge clk); bus.digit_in = 4'd5; bus.enter_btn = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("held_state", {30'd0, bus.entry_state}, 32'd1);
    chk("held_tens", {28'd0, bus.tens_digit}, 32'd5);
    chk("held_no_valid", pulses - p0, 32'd0);
    @(negedge clk); bus.enter_btn = 1'b0;
    repeat (20) @(posedge clk);
    press_clear();
    chk("clear_state", {30'd0, bus.entry_state}, 32'd0);

    // 64 is out of range
    press_enter(4'd6);
    press_enter(4'd4);
    chk("range_err", {31'd0, bus.err}, 32'd1);
    chk("range_state", {30'd0, bus.entry_state}, 32'd3);
    chk("range_keeps_value", {26'd0, bus.value_out}, 32'd42);
    press_enter(4'd1);
    chk("err_ignores_enter", {30'd0, bus.entry_state}, 32'd3);
    press_clear();
    chk("clr_err", {31'd0, bus.err}, 32'd0);
    chk("clr_state", {30'd0, bus.entry_state}, 32'd0);
    chk("clr_tens", {28'd0, bus.tens_digit}, 32'd0);
    chk("clr_units", {28'd0, bus.units_digit}, 32'd0);
    chk("clr_keeps_value", {26'd0, bus.value_out}, 32'd42);

    // Non-BCD tens digit
    press_enter(4'hA);
    chk("nonbcd_state", {30'd0, bus.entry_state}, 32'd3);
    chk("nonbcd_err", {31'd0, bus.err}, 32'd1);
    press_clear();

    // Boundary 63, then 00 entered from DONE
    exp_q.push_back(6'd63);
    press_enter(4'd6);
    press_enter(4'd3);
    chk("value_63", {26'd0, bus.value_out}, 32'd63);
    chk("state_63", {30'd0, bus.entry_state}, 32'd2);
    p0 = pulses;
    exp_q.push_back(6'd0);
    press_enter(4'd0);
    press_enter(4'd0);
    chk("value_00", {26'd0, bus.value_out}, 32'd0);
    chk("pulse_00", pulses - p0, 32'd1);

    // ENTER and CLEAR together in UNITS: CLEAR wins
    press_enter(4'd3);
    p0 = pulses;
    @(negedge clk);
    bus.digit_in  = 4'd1;
    bus.enter_btn = 1'b1;
    bus.clear_btn = 1'b1;
    repeat (D + 8) @(posedge clk);
    @(negedge clk);
    bus.enter_btn = 1'b0;
    bus.clear_btn = 1'b0;
    repeat (D + 8) @(posedge clk);
    #1;
    chk("both_state", {30'd0, bus.entry_state}, 32'd0);
    chk("both_tens", {28'd0, bus.tens_digit}, 32'd0);
    chk("both_no_valid", pulses - p0, 32'd0);

    // Reset mid-debounce discards the press
    exp_q.push_back(6'd38);
    press_enter(4'd3);
    press_enter(4'd8);
    chk("value_38", {26'd0, bus.value_out}, 32'd38);
    press_enter(4'd2);
    p0 = pulses;
    @(negedge clk);
    bus.digit_in  = 4'd1;
    bus.enter_btn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.enter_btn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_state", {30'd0, bus.entry_state}, 32'd0);
    chk("midrst_tens", {28'd0, bus.tens_digit}, 32'd0);
    chk("midrst_value", {26'd0, bus.value_out}, 32'd0);
    chk("midrst_no_valid", pulses - p0, 32'd0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_entry_to_bin.md
Name: bcd_entry_to_bin

Overview:
- Operator-side counterpart of the binary-to-two-digit 7-segment display path.
- Takes decimal digits entered on 4 slide switches, each confirmed by a raw ENTER pushbutton, and rebuilds a 2-digit decimal number (tens then units) into a binary value.
- The result is used as a processor state/address override.
- Echoes the entered digits for the existing 7-segment decoders.
- Includes button synchronisation, debounce, press-edge detection, an entry FSM and range checking.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the debounced button level changes; must be ≥2.
- OUT_WIDTH, 6: width of the binary result.
- MAX_VALUE, 63: largest accepted value. Must satisfy MAX_VALUE ≤ 99 and MAX_VALUE ≤ 2^OUT_WIDTH−1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- digit_in  input  4  BCD digit from switches, sampled on a confirmed press
- enter_btn  input  1  raw, asynchronous, bouncy ENTER button, active-high
- clear_btn  input  1  raw, asynchronous, bouncy CLEAR button, active-high
- value_out  output  OUT_WIDTH  last accepted binary value
- value_valid  output  1  one-cycle pulse when value_out updates
- err  output  1  level; entry rejected
- tens_digit  output  4  latched tens digit, for the display decoder
- units_digit  output  4  latched units digit, for the display decoder
- entry_state  output  2  FSM state: 0 TENS, 1 UNITS, 2 DONE, 3 ERR

Behaviour:
- Reset:
  - Applied on any clk edge with rst_n=0; valid mid-operation.
  - Clears synchronisers, debounce counters, debounced levels, press pulses and digit latches.
  - Output values after reset: value_out=0, value_valid=0, err=0, tens_digit=0, units_digit=0, entry_state=0 (TENS).
  - A press in flight during reset is discarded.
- Per-button front end (identical for ENTER and CLEAR):
  - Two-flop synchroniser feeds s.
  - Counter cnt: cleared whenever s equals the debounced level db.
  - Otherwise cnt increments; when cnt==DEBOUNCE_CYCLES−1 and s still differs, db<=s and cnt<=0.
  - Registered press pulse = db & ~db_prev, exactly 1 cycle wide.
  - Timing for a clean raw rise just before edge 1: db rises at edge DEBOUNCE_CYCLES+2, press is high after edge DEBOUNCE_CYCLES+3, and the FSM acts at edge DEBOUNCE_CYCLES+4.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no press.
  - Release is debounced the same way and generates no pulse.
  - A held button produces exactly one press.
- FSM, actions on an ENTER press (clear_press has priority in all states):
  - TENS: if digit_in>9, go to ERR. Otherwise tens_digit<=digit_in, units_digit<=0, go to UNITS.
  - UNITS: if digit_in>9, go to ERR. Otherwise units_digit<=digit_in and compute sum = tens_digit*10 + digit_in in 7 bits (max 99).
    - If sum>MAX_VALUE, go to ERR.
    - Otherwise value_out<=sum[OUT_WIDTH−1:0], value_valid=1 for the next cycle only, go to DONE.
  - DONE: value_out holds. The next ENTER press is treated as a new tens digit (same checks as TENS) and goes to UNITS.
  - ERR: err=1. ENTER presses are ignored. Leave only via CLEAR or reset.
- CLEAR press (any state): entry_state<=TENS, tens_digit<=0, units_digit<=0, err<=0. value_out is retained; value_valid is not pulsed.
- Simultaneous ENTER and CLEAR presses in the same cycle: CLEAR wins and the digit is discarded.
- err is 1 exactly when entry_state==ERR.
- value_valid is never asserted in consecutive cycles.
- digit_in is assumed static around the press and is sampled only in the FSM action cycle.

Test Plan:
- Reset, all inputs 0, rst_n low for 2 edges → every output 0, entry_state=0; after 100 idle cycles still no value_valid.
- DEBOUNCE_CYCLES=4: digit_in=4, clean ENTER press; then digit_in=2, clean ENTER press → tens_digit=4 at edge 8 after the first raw rise; after the second press value_out=42, value_valid high exactly 1 cycle, entry_state=2.
- ENTER raw pulses of 2 cycles and bouncing 1-0-1-0 shorter than 4 cycles → no press and no state change; an ENTER held 200 cycles → exactly one press.
- Entry 6 then 4 → err=1, entry_state=3, value_out keeps the prior 42; further ENTER presses ignored; CLEAR → err=0, entry_state=0, digits 0.
- digit_in=0xA on the tens press → ERR; 6 then 3 → value_out=63 accepted (boundary); 0 then 0 → value_out=0 with a value_valid pulse.
- ENTER and CLEAR raw rising on the same cycle in UNITS → CLEAR wins, state TENS, no value_valid; rst_n asserted mid-debounce → no press after reset release.
